pixel_frame_sequencer: RTL and testbench

- Parametrised successor to the fixed two-row pixel state machine.
- Sequences a global-shutter frame through four phases: erase, expose, convert and row read.
- Exposure length is programmable per frame; row count and ADC width are parameters.
- Drives the ADC ramp code, and hands rows out one at a time over a valid/ready handshake.
- Supports single-shot and continuous frame modes, plus a synchronous abort.
- Sits beside the pixel array, replacing the fixed-timing sequencer.

---
 rtl/pixel_frame_sequencer_if.sv | 26 ++
 rtl/pixel_frame_sequencer.sv | 164 ++++++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_sequencer_if.sv
// Row hand-off bus between the frame sequencer and the pixel read-out path:
// one-hot row select, row number and a valid/ready handshake.
interface pixel_frame_sequencer_if #(
  parameter int ROWS = 2
) ();
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [ROWS-1:0]  read;
  logic [ROW_W-1:0] row_index;
  logic             row_valid;
  logic             row_ready;

  modport master (
    output read,
    output row_index,
    output row_valid,
    input  row_ready
  );

  modport slave (
    input  read,
    input  row_index,
    input  row_valid,
    output row_ready
  );
endinterface

// File: rtl/pixel_frame_sequencer.sv
// Global-shutter frame sequencer: erase, expose, ADC ramp convert, then rows
// handed out one at a time over a valid/ready handshake.
module pixel_frame_sequencer #(
  parameter int ROWS         = 2,
  parameter int DATA_W       = 8,
  parameter int EXP_W        = 16,
  parameter int ERASE_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic                 abort,
  input  logic [EXP_W-1:0]     exposure_cycles,
  output logic                 erase,
  output logic                 expose,
  output logic                 convert,
  output logic [DATA_W-1:0]    adc_count,
  output logic                 busy,
  output logic                 frame_done,
  pixel_frame_sequencer_if.master row_bus
);

  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int WIDE_W  = (EXP_W > DATA_W) ? EXP_W : DATA_W;
  localparam int CNT_W   = (WIDE_W > ERASE_W) ? WIDE_W : ERASE_W;

  typedef enum logic [2:0] {
    IDLE,
    ERASE,
    EXPOSE,
    CONVERT,
    SETTLE,
    READ
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [EXP_W-1:0]   nexp_q, nexp_d;
  logic               frame_done_q, frame_done_d;
  logic [EXP_W-1:0]   exp_sat;
  logic [ROWS-1:0]    read_c;
  logic [ROW_W-1:0]   row_index_c;
  logic               row_valid_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      nexp_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      nexp_q       <= nexp_d;
      frame_done_q <= frame_done_d;
    end
  end

  // One shared phase counter; it restarts at 0 on every phase change.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    nexp_d       = nexp_q;
    frame_done_d = 1'b0;
    exp_sat      = (exposure_cycles == '0) ? EXP_W'(1) : exposure_cycles;

    case (state_q)
      IDLE: begin
        if (start) begin
          nexp_d  = exp_sat;
          cnt_d   = '0;
          state_d = ERASE;
        end
      end
      ERASE: begin
        if (cnt_q == CNT_W'(ERASE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = EXPOSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXPOSE: begin
        if (cnt_q == CNT_W'(nexp_q - EXP_W'(1))) begin
          cnt_d   = '0;
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'({DATA_W{1'b1}})) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SETTLE: begin
        state_d = READ;
      end
      READ: begin
        if (row_bus.row_ready) begin
          if (row_q == ROW_W'(ROWS - 1)) begin
            frame_done_d = 1'b1;
            row_d        = '0;
            cnt_d        = '0;
            if (continuous) begin
              nexp_d  = exp_sat;
              state_d = ERASE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = SETTLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over start and suppresses the pending frame_done pulse.
    if (abort) begin
      state_d      = IDLE;
      cnt_d        = '0;
      row_d        = '0;
      frame_done_d = 1'b0;
    end
  end

  always_comb begin
    erase       = (state_q == ERASE);
    expose      = (state_q == EXPOSE);
    convert     = (state_q == CONVERT);
    busy        = (state_q != IDLE);
    frame_done  = frame_done_q;
    adc_count   = '0;
    read_c      = '0;
    row_index_c = '0;
    row_valid_c = (state_q == READ);
    if (state_q == CONVERT) begin
      adc_count = cnt_q[DATA_W-1:0];
    end
    if ((state_q == SETTLE) || (state_q == READ)) begin
      read_c      = ROWS'(1) << row_q;
      row_index_c = row_q;
    end
  end

  assign row_bus.read      = read_c;
  assign row_bus.row_index = row_index_c;
  assign row_bus.row_valid = row_valid_c;

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Directed self-checking bench for pixel_frame_sequencer with ROWS=2,
// DATA_W=4, ERASE_CYCLES=4; inputs change 1 time unit after each rising edge.
module tb_pixel_frame_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic        abort;
  logic [15:0] exposure_cycles;
  logic        erase;
  logic        expose;
  logic        convert;
  logic [3:0]  adc_count;
  logic        busy;
  logic        frame_done;

  int assert_count = 0;
  int fail_count   = 0;

  pixel_frame_sequencer_if #(.ROWS(2)) row_bus ();

  pixel_frame_sequencer #(
    .ROWS(2),
    .DATA_W(4),
    .EXP_W(16),
    .ERASE_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .continuous(continuous),
    .abort(abort),
    .exposure_cycles(exposure_cycles),
    .erase(erase),
    .expose(expose),
    .convert(convert),
    .adc_count(adc_count),
    .busy(busy),
    .frame_done(frame_done),
    .row_bus(row_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic co, input logic ab,
                               input logic [15:0] ex, input logic rr);
    start               = st;
    continuous          = co;
    abort               = ab;
    exposure_cycles     = ex;
    row_bus.row_ready   = rr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert_count++;
    if (got !== want) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] packOut(logic er, logic ex, logic cv, logic [3:0] adc,
                                          logic [1:0] rd, logic ri, logic rv, logic bz, logic fd);
    return {19'b0, er, ex, cv, adc, rd, ri, rv, bz, fd};
  endfunction

  function automatic logic [31:0] observed();
    return packOut(erase, expose, convert, adc_count, row_bus.read,
                   row_bus.row_index[0], row_bus.row_valid, busy, frame_done);
  endfunction

  // Expected outputs c cycles after a start pulse, with zero backpressure.
  function automatic logic [31:0] frameModel(int c, int n);
    int ce;
    ce = 4 + n + 16;
    if (c < 1 || c > ce + 5) return '0;
    if (c <= 4)       return packOut(1, 0, 0, 4'd0, 2'b00, 0, 0, 1, 0);
    if (c <= 4 + n)   return packOut(0, 1, 0, 4'd0, 2'b00, 0, 0, 1, 0);
    if (c <= ce)      return packOut(0, 0, 1, 4'(c - (5 + n)), 2'b00, 0, 0, 1, 0);
    if (c == ce + 1)  return packOut(0, 0, 0, 4'd0, 2'b01, 0, 0, 1, 0);
    if (c == ce + 2)  return packOut(0, 0, 0, 4'd0, 2'b01, 0, 1, 1, 0);
    if (c == ce + 3)  return packOut(0, 0, 0, 4'd0, 2'b10, 1, 0, 1, 0);
    if (c == ce + 4)  return packOut(0, 0, 0, 4'd0, 2'b10, 1, 1, 1, 0);
    return packOut(0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 1);
  endfunction

  initial begin
    int exp_cnt;
    int fd_c;
    int pulse_c;
    logic pulsed;
    logic [31:0] want;

    reset = 1'b1;
    applyStimulus(0, 0, 0, 16'd0, 1'b0);
    tick();
    tick();
    checkOutput("reset_state", observed(), '0);
    reset = 1'b0;
    tick();
    checkOutput("idle_after_reset", observed(), '0);

    // Single shot, exposure 10, row_ready tied high
    applyStimulus(1, 0, 0, 16'd10, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 16'd10, 1'b1);
    for (int c = 1; c <= 37; c++) begin
      checkOutput($sformatf("single_c%0d", c), observed(), frameModel(c, 10));
      tick();
    end

    // Backpressure on row 0, ready pulse during row 1 SETTLE
    applyStimulus(1, 0, 0, 16'd2, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 16'd2, 1'b0);
    for (int i = 0; i < 100 && !row_bus.row_valid; i++) tick();
    checkOutput("bp_reach_read", {31'b0, row_bus.row_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bp_hold%0d", i), observed(),
                  packOut(0, 0, 0, 4'd0, 2'b01, 0, 1, 1, 0));
      tick();
    end
    applyStimulus(0, 0, 0, 16'd2, 1'b1);
    tick();
    checkOutput("bp_settle_row1", observed(), packOut(0, 0, 0, 4'd0, 2'b10, 1, 0, 1, 0));
    tick();
    checkOutput("bp_read_row1", observed(), packOut(0, 0, 0, 4'd0, 2'b10, 1, 1, 1, 0));
    applyStimulus(0, 0, 0, 16'd2, 1'b0);
    tick();
    checkOutput("bp_row1_hold", observed(), packOut(0, 0, 0, 4'd0, 2'b10, 1, 1, 1, 0));
    applyStimulus(0, 0, 0, 16'd2, 1'b1);
    tick();
    checkOutput("bp_done", observed(), packOut(0, 0, 0, 4'd0, 2'b00, 0, 0, 0, 1));
    tick();

    // Zero exposure, start pulse during CONVERT is ignored
    applyStimulus(1, 0, 0, 16'd0, 1'b1);
    tick();
    exp_cnt = 0;
    fd_c    = -1;
    pulse_c = -1;
    pulsed  = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (expose) exp_cnt++;
      if (frame_done) begin
        fd_c = c;
        break;
      end
      if (pulsed && c == pulse_c + 1) begin
        checkOutput("zx_busy_after_start", {30'b0, busy, convert}, 32'd3);
      end
      if (convert && !pulsed) begin
        applyStimulus(1, 0, 0, 16'd0, 1'b1);
        pulsed  = 1'b1;
        pulse_c = c;
      end else begin
        applyStimulus(0, 0, 0, 16'd0, 1'b1);
      end
      tick();
    end
    applyStimulus(0, 0, 0, 16'd0, 1'b1);
    checkOutput("zx_expose_len", 32'(exp_cnt), 32'd1);
    checkOutput("zx_convert_start", 32'(pulse_c), 32'd6);
    checkOutput("zx_latency", 32'(fd_c), 32'd26);
    tick();
    checkOutput("zx_not_queued0", observed(), '0);
    tick();
    checkOutput("zx_not_queued1", observed(), '0);

    // Continuous: frame 1 latches 3, frame 2 latches 7 at the restart
    applyStimulus(1, 1, 0, 16'd3, 1'b1);
    tick();
    applyStimulus(0, 1, 0, 16'd7, 1'b1);
    for (int c = 1; c <= 61; c++) begin
      want = '0;
      if (c <= 28) want = want | frameModel(c, 3);
      if (c >= 28) want = want | frameModel(c - 27, 7);
      checkOutput($sformatf("cont_c%0d", c), observed(), want);
      if (c == 40) applyStimulus(0, 0, 0, 16'd7, 1'b1);
      tick();
    end

    // Abort during EXPOSE together with a start
    applyStimulus(1, 0, 0, 16'd10, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 16'd10, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abort_pre_expose", {31'b0, expose}, 32'd1);
    applyStimulus(1, 0, 1, 16'd10, 1'b1);
    tick();
    applyStimulus(0, 0, 0, 16'd10, 1'b1);
    checkOutput("abort_idle", observed(), '0);
    tick();
    checkOutput("abort_start_ignored", observed(), '0);
    tick();
    checkOutput("abort_still_idle", observed(), '0);

    // Reset asserted during READ
    applyStimulus(1, 0, 0, 16'd1, 1'b0);
    tick();
    applyStimulus(0, 0, 0, 16'd1, 1'b0);
    for (int i = 0; i < 100 && !row_bus.row_valid; i++) tick();
    checkOutput("rst_reach_read", {31'b0, row_bus.row_valid}, 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("rst_in_read", observed(), '0);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 16'd1, 1'b1);
    tick();
    checkOutput("rst_idle_after", observed(), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
